// File: rtl/alu_share_ctrl.sv
// Two-requester round-robin front end for the shared combinational 16-bit ALU:
// registers the granted op onto the ALU bus and returns the result tagged by requester.
module alu_share_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [15:0]      req0_a,
    input  logic [15:0]      req0_b,
    input  logic [4:0]       req0_code,
    input  logic             req0_coe,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [15:0]      req1_a,
    input  logic [15:0]      req1_b,
    input  logic [4:0]       req1_code,
    input  logic             req1_coe,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic [4:0]       alu_code,
    output logic             alu_coe,
    input  logic [15:0]      alu_c,
    input  logic             alu_vout,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [15:0]      rsp_c,
    output logic             rsp_vout,
    output logic             rsp_cout,
    output logic             rsp_err,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    state_t state_nxt;
    logic   last;
    logic   gnt;
    logic   acc;
    logic   done;
    logic   op_id;

    function automatic logic code_defined(input logic [4:0] code);
        case (code)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5,
            5'd8, 5'd9, 5'd10, 5'd12,
            5'd16, 5'd17, 5'd18, 5'd19,
            5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29: code_defined = 1'b1;
            default:                                  code_defined = 1'b0;
        endcase
    endfunction

    // On a tie the requester not served last wins; otherwise the lone valid one.
    always_comb begin
        gnt = req1_valid;
        if (req0_valid && req1_valid) begin
            gnt = ~last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && state == IDLE) begin
            req0_ready = req0_valid & ~gnt;
            req1_ready = req1_valid & gnt;
        end
        acc  = req0_ready | req1_ready;
        done = (state == RESP) & rsp_ready;
    end

    // Operand, response and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_code  <= '0;
            alu_coe   <= 1'b1;
            op_id     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_c     <= '0;
            rsp_vout  <= 1'b0;
            rsp_cout  <= 1'b0;
            rsp_err   <= 1'b0;
            ops_done  <= '0;
            last      <= 1'b1;
        end else begin
            if (acc) begin
                alu_a    <= gnt ? req1_a    : req0_a;
                alu_b    <= gnt ? req1_b    : req0_b;
                alu_code <= gnt ? req1_code : req0_code;
                alu_coe  <= gnt ? req1_coe  : req0_coe;
                op_id    <= gnt;
            end
            if (state == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= op_id;
                rsp_c     <= alu_c;
                rsp_vout  <= alu_vout;
                rsp_cout  <= alu_cout;
                rsp_err   <= ~code_defined(alu_code);
            end else if (done) begin
                rsp_valid <= 1'b0;
            end
            if (done) begin
                ops_done <= ops_done + CNT_W'(1);
                last     <= rsp_id;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU stub, per-cycle reference model and
// directed scenarios with hand-computed expectations.
module tb_alu_share_ctrl;

    typedef struct packed {
        logic [15:0] c;
        logic        v;
        logic        co;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_coe;
    logic [15:0] req0_a, req0_b;
    logic [4:0]  req0_code;
    logic        req1_valid, req1_ready, req1_coe;
    logic [15:0] req1_a, req1_b;
    logic [4:0]  req1_code;
    logic [15:0] alu_a, alu_b, alu_c;
    logic [4:0]  alu_code;
    logic        alu_coe, alu_vout, alu_cout;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_vout, rsp_cout, rsp_err;
    logic [15:0] rsp_c;
    logic [15:0] ops_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_code(req0_code), .req0_coe(req0_coe),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_code(req1_code), .req1_coe(req1_coe),
        .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code), .alu_coe(alu_coe),
        .alu_c(alu_c), .alu_vout(alu_vout), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_c(rsp_c), .rsp_vout(rsp_vout), .rsp_cout(rsp_cout),
        .rsp_err(rsp_err), .ops_done(ops_done)
    );

    function automatic logic is_defined(input logic [4:0] code);
        return code inside {[5'd0:5'd5], 5'd8, 5'd9, 5'd10, 5'd12, [5'd16:5'd19], [5'd24:5'd29]};
    endfunction

    // Small ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not-a, other defined codes pass a.
    function automatic res_t alu_ref(input logic [15:0] a, input logic [15:0] b,
                                     input logic [4:0] code, input logic coe);
        res_t        r;
        logic [16:0] s;
        r = '0;
        s = '0;
        case (code)
            5'd0: begin
                s   = {1'b0, a} + {1'b0, b};
                r.v = (a[15] == b[15]) && (s[15] != a[15]);
            end
            5'd1: begin
                s   = {1'b0, a} + {1'b0, ~b} + 17'd1;
                r.v = (a[15] != b[15]) && (s[15] != a[15]);
            end
            5'd2:    s = {1'b0, a & b};
            5'd3:    s = {1'b0, a | b};
            5'd4:    s = {1'b0, a ^ b};
            5'd5:    s = {1'b0, ~a};
            default: s = is_defined(code) ? {1'b0, a} : 17'd0;
        endcase
        r.c  = s[15:0];
        r.co = !coe && s[16];
        return r;
    endfunction

    res_t alu_out;
    always_comb begin
        alu_out  = alu_ref(alu_a, alu_b, alu_code, alu_coe);
        alu_c    = alu_out.c;
        alu_vout = alu_out.v;
        alu_cout = alu_out.co;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: idle / executing / responding, advanced once per clock.
    int          m_phase = 0;
    logic        m_last = 1'b1;
    logic [15:0] m_ops = '0;
    logic [15:0] m_a = '0, m_b = '0;
    logic [4:0]  m_code = '0;
    logic        m_coe = 1'b1, m_id = 1'b0, m_err = 1'b0;
    res_t        m_res = '0;

    initial begin
        forever begin
            logic g, e0, e1, acc, done;
            @(negedge clk);
            g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e0 = !rst && m_phase == 0 && req0_valid && !g;
            e1 = !rst && m_phase == 0 && req1_valid && g;
            chk("m_req0_ready", 32'(req0_ready), 32'(e0));
            chk("m_req1_ready", 32'(req1_ready), 32'(e1));
            chk("m_alu_bus", {alu_a, alu_b}, {m_a, m_b});
            chk("m_alu_ctl", 32'({alu_code, alu_coe}), 32'({m_code, m_coe}));
            chk("m_rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
            chk("m_ops_done", 32'(ops_done), 32'(m_ops));
            if (m_phase == 2) begin
                chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
                chk("m_rsp_c", 32'(rsp_c), 32'(m_res.c));
                chk("m_rsp_flags", 32'({rsp_vout, rsp_cout, rsp_err}),
                    32'({m_res.v, m_res.co, m_err}));
            end
            acc  = e0 || e1;
            done = m_phase == 2 && rsp_ready;
            @(posedge clk);
            if (rst) begin
                m_phase = 0; m_last = 1'b1; m_ops = '0;
                m_a = '0; m_b = '0; m_code = '0; m_coe = 1'b1;
            end else if (acc) begin
                m_id   = g;
                m_a    = g ? req1_a : req0_a;
                m_b    = g ? req1_b : req0_b;
                m_code = g ? req1_code : req0_code;
                m_coe  = g ? req1_coe : req0_coe;
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_res   = alu_ref(m_a, m_b, m_code, m_coe);
                m_err   = !is_defined(m_code);
                m_phase = 2;
            end else if (done) begin
                m_ops   = m_ops + 16'd1;
                m_last  = m_id;
                m_phase = 0;
            end
        end
    end

    task automatic issue(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] code, input logic coe);
        logic got;
        got = 1'b0;
        if (id) begin
            req1_a = a; req1_b = b; req1_code = code; req1_coe = coe; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_code = code; req0_coe = coe; req0_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
            @(posedge clk); #1;
        end
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout id=%0d", id);
        end
    endtask

    task automatic get_rsp(output res_t r, output logic id, output logic err, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        r = '0; id = 1'b0; err = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid && rsp_ready) begin
                got = 1'b1;
                r = {rsp_c, rsp_vout, rsp_cout};
                id = rsp_id;
                err = rsp_err;
            end
        end
        @(posedge clk); #1;
        if (!got) begin
            errors++;
            $display("FAIL rsp_timeout");
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        res_t        r;
        logic        id, err;
        int          lat;
        int          gnt_q[$];
        logic [16:0] rsp_q[$];
        int          n0, n1;

        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 16'h0005; req0_b = 16'h0003; req0_code = 5'd0; req0_coe = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_code = '0; req1_coe = 1'b1;

        // Reset values, with req0 already pending.
        @(negedge clk);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_alu", {alu_a, alu_b}, 32'd0);
        chk("rst_alu_coe", 32'({alu_code, alu_coe}), 32'h1);
        chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_c, rsp_vout, rsp_cout, rsp_err}), 32'd0);
        chk("rst_ops", 32'(ops_done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single op: 5 + 3.
        @(negedge clk);
        chk("single_ready", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        get_rsp(r, id, err, lat);
        chk("single_latency", 32'(lat), 32'd2);
        chk("single_id", 32'(id), 32'd0);
        chk("single_c", 32'(r.c), 32'h0008);
        chk("single_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("single_ops", 32'(ops_done), 32'd1);
        @(posedge clk); #1;

        // Tie arbitration from a fresh reset: req0 wins first.
        pulse_reset();
        req0_a = 16'd10; req0_b = 16'd3; req0_code = 5'd1; req0_coe = 1'b0; req0_valid = 1'b1;
        req1_a = 16'hFF00; req1_b = 16'h0FF0; req1_code = 5'd4; req1_coe = 1'b1; req1_valid = 1'b1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 60 && rsp_q.size() < 4; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) begin gnt_q.push_back(0); n0++; end
            if (req1_valid && req1_ready) begin gnt_q.push_back(1); n1++; end
            if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_id, rsp_c});
            @(posedge clk); #1;
            if (n0 >= 2) req0_valid = 1'b0;
            if (n1 >= 2) req1_valid = 1'b0;
        end
        chk("tie_grants", 32'(gnt_q.size()), 32'd4);
        chk("tie_rsps", 32'(rsp_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < gnt_q.size() && i < rsp_q.size(); i++) begin
            chk("tie_order", 32'(gnt_q[i]), 32'(i % 2));
            chk("tie_rsp", 32'(rsp_q[i]), (i % 2 == 0) ? 32'h0_0007 : 32'h1_F0F0);
        end

        // Backpressure: hold response for 5 cycles with req1 waiting.
        rsp_ready = 1'b0;
        issue(1'b0, 16'h0001, 16'h0002, 5'd0, 1'b0);
        req1_a = 16'h0004; req1_b = 16'h0004; req1_code = 5'd0; req1_coe = 1'b0; req1_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_c", 32'(rsp_c), 32'h0003);
            chk("bp_readies", 32'({req0_ready, req1_ready}), 32'd0);
            chk("bp_ops", 32'(ops_done), 32'd4);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        get_rsp(r, id, err, lat);
        chk("bp_release_c", 32'(r.c), 32'h0003);
        issue(1'b1, 16'h0004, 16'h0004, 5'd0, 1'b0);
        get_rsp(r, id, err, lat);
        chk("bp_next", 32'({id, r.c}), 32'h1_0008);

        // Undefined code 11.
        issue(1'b0, 16'h1234, 16'h0000, 5'b01011, 1'b1);
        get_rsp(r, id, err, lat);
        chk("undef_err", 32'(err), 32'd1);
        chk("undef_c", 32'(r.c), 32'h0000);
        @(negedge clk);
        chk("undef_ops", 32'(ops_done), 32'd7);
        @(posedge clk); #1;

        // Signed overflow on 7FFF + 1.
        issue(1'b1, 16'h7FFF, 16'h0001, 5'd0, 1'b0);
        get_rsp(r, id, err, lat);
        chk("flags_c", 32'(r.c), 32'h8000);
        chk("flags_vc", 32'({r.v, r.co}), 32'b10);

        // Reset while executing aborts the op.
        issue(1'b0, 16'h0005, 16'h0005, 5'd0, 1'b0);
        pulse_reset();
        @(negedge clk);
        chk("abort_valid", 32'(rsp_valid), 32'd0);
        chk("abort_ops", 32'(ops_done), 32'd0);
        chk("abort_coe", 32'(alu_coe), 32'd1);
        @(posedge clk); #1;
        issue(1'b1, 16'h0002, 16'h0002, 5'd0, 1'b0);
        get_rsp(r, id, err, lat);
        chk("after_abort", 32'({id, r.c}), 32'h1_0004);
        @(negedge clk);
        chk("after_abort_ops", 32'(ops_done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
